// File: rtl/inst_fetch_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_bridge_pkg
// Description : Shared definitions for the fetch-side instruction bridge:
//               FSM state encoding and the default bubble instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_bridge_pkg;

    // Bubble driven on the instruction bus whenever no valid fetch is present
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no transaction, waiting for a fetch request
        ST_REQ  = 2'd1,   // request on the bus, waiting for address accept
        ST_WAIT = 2'd2,   // address accepted, waiting for read data
        ST_HOLD = 2'd3    // word returned while decode stalled; held locally
    } fetchState_t;

endpackage : inst_fetch_bridge_pkg
`default_nettype wire

// File: rtl/inst_fetch_bridge_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_bridge_hold_buf
// Description : Instruction hold buffer. A 32-bit enable register that
//               captures the returned word while decode is stalled.
// Ports       : clk      - system clock
//               rst      - asynchronous active-low reset (loads RESET_VAL)
//               i_en     - load enable
//               i_d      - data in
//               o_q      - registered data out
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_bridge_hold_buf #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : inst_fetch_bridge_hold_buf
`default_nettype wire

// File: rtl/inst_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_bridge
// Description : Fetch-side bridge between the PC register and an SRAM-like
//               instruction port (req / addr_ok / data_ok). At most one
//               transaction is outstanding. Returned words go straight to the
//               F->D register, or into a hold buffer while decode stalls.
//               Responses made stale by a redirect are discarded.
// Ports       : clk, rst (async active-low)
//               pcF, fetch_en, pipe_stall, flush  - pipeline side inputs
//               instrF, instr_valid, fetch_stall, adelF - pipeline outputs
//               inst_req, inst_addr               - SRAM request
//               inst_addr_ok, inst_data_ok, inst_rdata - SRAM response
// Config      : FETCH_ADDR_CHECK_EN - when defined, a misaligned pcF is never
//               requested; a one-cycle adelF/instr_valid bubble is produced
//               instead. When undefined adelF is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        fetch_en,
    input  logic        pipe_stall,
    input  logic        flush,
    output logic [31:0] instrF,
    output logic        instr_valid,
    output logic        fetch_stall,
    output logic        adelF,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    fetchState_t r_state;
    fetchState_t w_stateNext;
    logic        r_discard;
    logic        w_discardNext;
    logic        w_holdEn;
    logic [31:0] w_holdQ;
    logic        w_deliver;
    logic        w_adel;

    inst_fetch_bridge_hold_buf #(
        .RESET_VAL (NOP_INSTR)
    ) u_holdBuf (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_holdEn),
        .i_d  (inst_rdata),
        .o_q  (w_holdQ)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_discard <= w_discardNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_discardNext = r_discard;
        w_holdEn      = 1'b0;
        w_deliver     = 1'b0;
        w_adel        = 1'b0;
        inst_req      = 1'b0;
        instr_valid   = 1'b0;
        instrF        = NOP_INSTR;

        case (r_state)
            ST_IDLE: begin
                if (fetch_en) begin
                    w_stateNext = ST_REQ;
                end
            end

            ST_REQ: begin
`ifdef FETCH_ADDR_CHECK_EN
                if (pcF[1:0] != 2'b00) begin
                    // Misaligned: never reaches the bus; hand decode a bubble
                    // tagged with the address error, unless redirected away.
                    w_adel      = ~flush;
                    instr_valid = ~flush;
                    w_deliver   = ~flush;
                    w_stateNext = ST_IDLE;
                end else
`endif
                begin
                    inst_req = 1'b1;
                    if (inst_addr_ok) begin
                        w_stateNext = ST_WAIT;
                        // Accepted address belongs to the old PC stream
                        if (flush) begin
                            w_discardNext = 1'b1;
                        end
                    end
                end
            end

            ST_WAIT: begin
                if (flush) begin
                    w_discardNext = 1'b1;
                end
                if (inst_data_ok) begin
                    if (r_discard || flush) begin
                        w_discardNext = 1'b0;
                        w_stateNext   = fetch_en ? ST_REQ : ST_IDLE;
                    end else if (pipe_stall) begin
                        w_holdEn    = 1'b1;
                        w_stateNext = ST_HOLD;
                    end else begin
                        instrF      = inst_rdata;
                        instr_valid = 1'b1;
                        w_deliver   = 1'b1;
                        w_stateNext = fetch_en ? ST_REQ : ST_IDLE;
                    end
                end
            end

            ST_HOLD: begin
                if (flush) begin
                    w_stateNext = ST_REQ;
                end else begin
                    instrF      = w_holdQ;
                    instr_valid = 1'b1;
                    if (!pipe_stall) begin
                        w_stateNext = fetch_en ? ST_REQ : ST_IDLE;
                    end
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign inst_addr   = pcF;
    assign adelF       = w_adel;
    assign fetch_stall = ~(w_deliver | (r_state == ST_HOLD));

endmodule : inst_fetch_bridge
`default_nettype wire
